// File: rtl/lms_seq_if.sv
// lms_seq_if -- port bundle for the LMS filter sequencer.
//
// Purpose: groups the frame-start pulse, mode inputs and the datapath
// control strobes/status of lms_seq_ctrl into one interface.
//
// Handshake: head_flag is a one-cycle pulse with no backpressure. The
// sequencer accepts it only in IDLE or DONE. In any other state the frame is
// dropped and overrun/ovr_cnt record the loss. dout_valid is a one-cycle
// pulse with no ready.
//
// Ports (seen from the slave / sequencer side):
//   in  head_flag, adapt_en, ovr_clr
//   out shift_en, mac_clr, mac_en, err_latch, wupd_en, tap_idx[IW-1:0],
//       dout_valid, busy, overrun, ovr_cnt[7:0], state_dbg[2:0]
interface lms_seq_if #(
    parameter int IW = 5
);
    logic          head_flag;
    logic          adapt_en;
    logic          ovr_clr;
    logic          shift_en;
    logic          mac_clr;
    logic          mac_en;
    logic          err_latch;
    logic          wupd_en;
    logic [IW-1:0] tap_idx;
    logic          dout_valid;
    logic          busy;
    logic          overrun;
    logic [7:0]    ovr_cnt;
    logic [2:0]    state_dbg;

    modport master (
        output head_flag, adapt_en, ovr_clr,
        input  shift_en, mac_clr, mac_en, err_latch, wupd_en, tap_idx,
               dout_valid, busy, overrun, ovr_cnt, state_dbg
    );

    modport slave (
        input  head_flag, adapt_en, ovr_clr,
        output shift_en, mac_clr, mac_en, err_latch, wupd_en, tap_idx,
               dout_valid, busy, overrun, ovr_cnt, state_dbg
    );
endinterface

// File: rtl/lms_seq_ctrl.sv
// lms_seq_ctrl -- control sequencer for a TAPS-order LMS adaptive filter.
//
// Purpose: for each accepted frame, the sequencer runs the following phases:
//   SHIFT: the delay line is shifted.
//   MAC:   TAPS multiply-accumulate cycles run.
//   ERR:   the error is latched.
//   UPD:   TAPS optional weight-update cycles run.
//   DONE:  a one-cycle dout_valid pulse is issued.
// Frames arriving while busy (except in DONE) are dropped and recorded.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - lms_seq_if.slave (head_flag/adapt_en/ovr_clr in; strobes,
//          tap_idx, dout_valid, busy, overrun, ovr_cnt, state_dbg out)
//
// Parameters: TAPS (filter order), IW (tap_idx width). TAPS <= 2**IW.
//
// Configuration macro: LMS_SEQ_OVR_CNT_EN
//   defined   - ovr_cnt counts dropped frames, saturating at 255.
//   undefined - ovr_cnt is constant 0 and no counter register exists.
module lms_seq_ctrl #(
    parameter int TAPS = 32,
    parameter int IW   = 5
) (
    input  logic      clk,
    input  logic      rst,
    lms_seq_if.slave  bus
);

    if (TAPS < 1 || TAPS > (2 ** IW)) begin : g_bad_taps
        $error("lms_seq_ctrl: TAPS must be in 1..2**IW");
    end

    localparam logic [IW-1:0] TAP_LAST = IW'(TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_MAC   = 3'd2,
        S_ERR   = 3'd3,
        S_UPD   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] tap_q, tap_d;
    logic          overrun_q, overrun_d;
    logic          drop;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tap_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state. tap_d defaults to 0 so the counter sits at 0 in every state
    // other than MAC/UPD. It returns to 0 on the exit of those states and so
    // never reaches TAPS.
    always_comb begin
        state_d = state_q;
        tap_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.head_flag) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                if (tap_q == TAP_LAST) state_d = S_ERR;
                else                   tap_d   = tap_q + IW'(1);
            end
            S_ERR: begin
                // adapt_en matters only here; the frame's mode is fixed now.
                state_d = bus.adapt_en ? S_UPD : S_DONE;
            end
            S_UPD: begin
                if (tap_q == TAP_LAST) state_d = S_DONE;
                else                   tap_d   = tap_q + IW'(1);
            end
            S_DONE: begin
                // Back-to-back frame: a head_flag in DONE is accepted.
                state_d = bus.head_flag ? S_SHIFT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A frame is dropped when it arrives while the pipeline is mid-frame.
    // A drop beats ovr_clr in the same cycle.
    always_comb begin
        drop = bus.head_flag &&
               (state_q == S_SHIFT || state_q == S_MAC ||
                state_q == S_ERR   || state_q == S_UPD);
        overrun_d = overrun_q;
        if (drop)             overrun_d = 1'b1;
        else if (bus.ovr_clr) overrun_d = 1'b0;
    end

`ifdef LMS_SEQ_OVR_CNT_EN
    logic [7:0] cnt_q;

    // A drop together with ovr_clr restarts the count at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (drop) begin
            if (bus.ovr_clr)         cnt_q <= 8'd1;
            else if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        end else if (bus.ovr_clr) begin
            cnt_q <= 8'd0;
        end
    end

    assign bus.ovr_cnt = cnt_q;
`else
    assign bus.ovr_cnt = 8'd0;
`endif

    // Outputs are decoded from registered state only (no head_flag path).
    assign bus.shift_en   = (state_q == S_SHIFT);
    assign bus.mac_en     = (state_q == S_MAC);
    assign bus.mac_clr    = (state_q == S_MAC) && (tap_q == '0);
    assign bus.err_latch  = (state_q == S_ERR);
    assign bus.wupd_en    = (state_q == S_UPD);
    assign bus.dout_valid = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.tap_idx    = tap_q;
    assign bus.overrun    = overrun_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_lms_seq_ctrl.sv
// tb_lms_seq_ctrl -- self-checking bench for lms_seq_ctrl (TAPS=32, IW=5).
// Expected output vectors come from the documented frame latencies and are
// queued as stimulus is driven, then popped one cycle later and compared.
module tb_lms_seq_ctrl;
    localparam int TAPS = 32;
    localparam int IW   = 5;
    localparam int VW   = 8 + 8 + IW;

    typedef logic [VW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;

    lms_seq_if #(.IW(IW)) bus ();

    lms_seq_ctrl #(.TAPS(TAPS), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   m_ovr = 1'b0;
    int   m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cnt_model(input int n);
`ifdef LMS_SEQ_OVR_CNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0 + 8'(n - n);
`endif
    endfunction

    // Expected outputs k cycles after an accepted head_flag (k=0: still idle).
    function automatic vec_t frame_vec(input int k, input bit adapt, input bit ovr, input logic [7:0] cnt);
        int done = adapt ? 2*TAPS + 3 : TAPS + 3;
        bit busy = (k >= 1) && (k <= done);
        bit sh   = (k == 1);
        bit mac  = (k >= 2) && (k <= TAPS + 1);
        bit clr  = (k == 2);
        bit err  = (k == TAPS + 2);
        bit upd  = adapt && (k >= TAPS + 3) && (k <= 2*TAPS + 2);
        bit dv   = (k == done);
        int tap  = mac ? k - 2 : (upd ? k - TAPS - 3 : 0);
        return {busy, sh, clr, mac, err, upd, dv, ovr, cnt, IW'(tap)};
    endfunction

    function automatic vec_t act_vec();
        return {bus.busy, bus.shift_en, bus.mac_clr, bus.mac_en, bus.err_latch,
                bus.wupd_en, bus.dout_valid, bus.overrun, bus.ovr_cnt, bus.tap_idx};
    endfunction

    // Expected vector at cycle c of a test scenario; also returns the
    // modelled overrun state so the next test can start from it.
    function automatic vec_t exp_at(input int c, input bit adapt, input int drop_c,
                                    input bit clr_at_drop, input int restart_c, input int rst_c,
                                    output bit e_ovr, output int e_cnt);
        if (rst_c >= 0 && c > rst_c) begin
            e_ovr = 1'b0; e_cnt = 0;
        end else if (drop_c >= 0 && c > drop_c) begin
            e_ovr = 1'b1; e_cnt = clr_at_drop ? 1 : m_cnt + 1;
        end else begin
            e_ovr = m_ovr; e_cnt = m_cnt;
        end
        if (restart_c >= 0 && c > restart_c)
            return frame_vec(c - restart_c, adapt, e_ovr, cnt_model(e_cnt));
        else if (rst_c >= 0 && c > rst_c)
            return frame_vec(0, adapt, e_ovr, cnt_model(e_cnt));
        else
            return frame_vec(c, adapt, e_ovr, cnt_model(e_cnt));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: head_flag at 0, optional drop at drop_c, optional restart at
    // restart_c, optional reset at rst_c. adapt_en is randomised except in
    // the ERR cycle of each frame, where it takes the test's mode.
    task automatic run_test(input string name, input bit adapt, input int drop_c,
                            input bit clr_at_drop, input int restart_c, input int rst_c);
        int   last_start = (restart_c >= 0) ? restart_c : 0;
        int   n = last_start + (adapt ? 2*TAPS + 3 : TAPS + 3) + 3;
        bit   e_ovr;
        int   e_cnt;
        vec_t v;
        exp_q.push_back(exp_at(0, adapt, drop_c, clr_at_drop, restart_c, rst_c, e_ovr, e_cnt));
        for (int c = 0; c <= n; c++) begin
            v = exp_q.pop_front();
            chk($sformatf("%s c%0d", name, c), 32'(act_vec()), 32'(v));
            bus.head_flag = (c == 0) || (c == drop_c) || (c == restart_c);
            bus.ovr_clr   = clr_at_drop && (c == drop_c);
            rst           = (c == rst_c);
            if (c == TAPS + 2 || (restart_c >= 0 && c == restart_c + TAPS + 2))
                bus.adapt_en = adapt;
            else
                bus.adapt_en = 1'($urandom_range(0, 1));
            exp_q.push_back(exp_at(c + 1, adapt, drop_c, clr_at_drop, restart_c, rst_c, e_ovr, e_cnt));
            step();
        end
        void'(exp_q.pop_front());
        bus.head_flag = 1'b0;
        bus.ovr_clr   = 1'b0;
        rst           = 1'b0;
        m_ovr = e_ovr;
        m_cnt = e_cnt;
    endtask

    task automatic clear_ovr(input string name);
        bus.ovr_clr = 1'b1;
        step();
        bus.ovr_clr = 1'b0;
        chk({name, "_ovr"}, 32'(bus.overrun), 32'(0));
        chk({name, "_cnt"}, 32'(bus.ovr_cnt), 32'(0));
        m_ovr = 1'b0;
        m_cnt = 0;
    endtask

    initial begin
        int waited;
        // Reset with head_flag held high: it must be ignored.
        rst           = 1'b1;
        bus.head_flag = 1'b1;
        bus.adapt_en  = 1'b1;
        bus.ovr_clr   = 1'b0;
        repeat (3) step();

        // First frame in the first cycle after reset deasserts.
        run_test("basic",   1'b1, -1, 1'b0, -1, -1);
        run_test("noadapt", 1'b0, -1, 1'b0, -1, -1);
        run_test("drop",    1'b1, 20, 1'b0, -1, -1);
        run_test("dropclr", 1'b1, 10, 1'b1, -1, -1);
        clear_ovr("clr1");
        run_test("restart", 1'b1, -1, 1'b0, 2*TAPS + 3, -1);
        run_test("midrst",  1'b1, 30, 1'b0, 42, 40);

        // Saturation: head_flag held high, most frames dropped.
        bus.adapt_en  = 1'b1;
        bus.head_flag = 1'b1;
        repeat (2*TAPS + 3) step();
        chk("sat_cnt66", 32'(bus.ovr_cnt), 32'(cnt_model(2*TAPS + 2)));
        chk("sat_ovr66", 32'(bus.overrun), 32'(1));
        repeat (333) step();
        bus.head_flag = 1'b0;
        waited = 0;
        while (bus.busy && waited < 200) begin
            step();
            waited++;
        end
        chk("sat_idle", 32'(bus.busy), 32'(0));
        chk("sat_ovr", 32'(bus.overrun), 32'(1));
        chk("sat_cnt", 32'(bus.ovr_cnt), 32'(cnt_model(300)));
        clear_ovr("clr2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
